vote_block_cipher: RTL and testbench



---
 rtl/vote_block_cipher.sv | 150 +++++++++++++++
 tb/tb_vote_block_cipher.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_block_cipher.sv
`default_nettype none
// ============================================================================
// Module   : vote_block_cipher
// Brief    : Iterative 64-bit Feistel cipher, one round per clock, for vote
//            records. Optional decrypt mode via VOTE_CIPHER_DECRYPT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vote_block_cipher #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [0:63] plaintext,
    input  logic [0:63] final_key,
`ifdef VOTE_CIPHER_DECRYPT_EN
    input  logic        decrypt,
`endif
    output logic        ready,
    output logic        busy,
    output logic        valid,
    output logic [0:63] ciphertext
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;
    localparam logic [4:0] c_LAST = 5'(ROUNDS - 1);

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [0:31] r_l;
    logic [0:31] r_r;
    logic [0:63] r_key;
    logic [4:0]  r_i;
    logic [0:63] r_ct;
    logic        r_valid;

    logic        w_accept;
    logic        w_last;
    logic [0:31] w_k;
    logic [0:31] w_l_next;
    logic [0:31] w_r_next;
    logic [0:63] w_key_next;
    logic [4:0]  w_i_next;
    logic [0:63] w_load_key;
    logic [4:0]  w_load_i;

    function automatic logic [0:31] feistel_f(input logic [0:31] x, input logic [0:31] k);
        return ({x[5:31], x[0:4]} + k) ^ x;
    endfunction

    assign w_accept = (r_state == c_IDLE) && start;
    assign w_k      = r_key[0:31] ^ {27'b0, r_i};

`ifdef VOTE_CIPHER_DECRYPT_EN
    localparam int c_DEC_ROT = (8 * (ROUNDS - 1)) % 64;

    logic r_dec;

    // Decrypt walks the schedule backwards: start at K_{ROUNDS-1}, unrotate.
    always_comb begin
        w_last     = r_dec ? (r_i == 5'd0) : (r_i == c_LAST);
        w_load_key = decrypt ? ((final_key << c_DEC_ROT) | (final_key >> (64 - c_DEC_ROT)))
                             : final_key;
        w_load_i   = decrypt ? c_LAST : 5'd0;
        if (r_dec) begin
            w_l_next   = r_r ^ feistel_f(r_l, w_k);
            w_r_next   = r_l;
            w_key_next = {r_key[56:63], r_key[0:55]};
            w_i_next   = r_i - 5'd1;
        end else begin
            w_l_next   = r_r;
            w_r_next   = r_l ^ feistel_f(r_r, w_k);
            w_key_next = {r_key[8:63], r_key[0:7]};
            w_i_next   = r_i + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dec <= 1'b0;
        end else if (w_accept) begin
            r_dec <= decrypt;
        end
    end
`else
    always_comb begin
        w_last     = (r_i == c_LAST);
        w_load_key = final_key;
        w_load_i   = 5'd0;
        w_l_next   = r_r;
        w_r_next   = r_l ^ feistel_f(r_r, w_k);
        w_key_next = {r_key[8:63], r_key[0:7]};
        w_i_next   = r_i + 5'd1;
    end
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start)  w_state_next = c_RUN;
            c_RUN:   if (w_last) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_l     <= '0;
            r_r     <= '0;
            r_key   <= '0;
            r_i     <= '0;
            r_ct    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_l   <= plaintext[0:31];
                r_r   <= plaintext[32:63];
                r_key <= w_load_key;
                r_i   <= w_load_i;
            end else if (r_state == c_RUN) begin
                r_l   <= w_l_next;
                r_r   <= w_r_next;
                r_key <= w_key_next;
                r_i   <= w_i_next;
                // No final swap: the last round's (L,R) is the ciphertext.
                if (w_last) begin
                    r_ct    <= {w_l_next, w_r_next};
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign ready      = (r_state == c_IDLE);
    assign busy       = ~ready;
    assign valid      = r_valid;
    assign ciphertext = r_ct;

endmodule
`default_nettype wire

// File: tb/tb_vote_block_cipher.sv
`default_nettype none
// ============================================================================
// Module   : tb_vote_block_cipher
// Brief    : Self-checking bench for vote_block_cipher (ROUNDS = 1, 2, 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vote_block_cipher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] pt;
    logic [63:0] key;
    logic        dec;
    logic        st1, st2, st16;
    logic        rdy1, bsy1, vld1;
    logic        rdy2, bsy2, vld2;
    logic        rdy16, bsy16, vld16;
    logic [63:0] ct1, ct2, ct16;

    int errors = 0;
    int checks = 0;

    vote_block_cipher #(.ROUNDS(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .plaintext(pt), .final_key(key),
`ifdef VOTE_CIPHER_DECRYPT_EN
        .decrypt(dec),
`endif
        .ready(rdy1), .busy(bsy1), .valid(vld1), .ciphertext(ct1)
    );

    vote_block_cipher #(.ROUNDS(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .plaintext(pt), .final_key(key),
`ifdef VOTE_CIPHER_DECRYPT_EN
        .decrypt(dec),
`endif
        .ready(rdy2), .busy(bsy2), .valid(vld2), .ciphertext(ct2)
    );

    vote_block_cipher #(.ROUNDS(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .plaintext(pt), .final_key(key),
`ifdef VOTE_CIPHER_DECRYPT_EN
        .decrypt(dec),
`endif
        .ready(rdy16), .busy(bsy16), .valid(vld16), .ciphertext(ct16)
    );

    // Reference: subkey K_i derived directly from the key rotated by 8*i.
    function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
        int m;
        m = n % 64;
        if (m == 0) return x;
        return (x << m) | (x >> (64 - m));
    endfunction

    function automatic logic [31:0] ref_f(input logic [31:0] x, input logic [31:0] k);
        logic [31:0] rx;
        rx = {x[26:0], x[31:27]};
        return (rx + k) ^ x;
    endfunction

    function automatic logic [63:0] ref_model(input logic [63:0] p, input logic [63:0] k,
                                              input int rounds, input logic d);
        logic [31:0] l, r, sk, t;
        logic [63:0] rk;
        int idx;
        l = p[63:32];
        r = p[31:0];
        for (int s = 0; s < rounds; s++) begin
            idx = d ? (rounds - 1 - s) : s;
            rk  = rotl64(k, 8 * idx);
            sk  = rk[63:32] ^ 32'(idx);
            if (!d) begin
                t = l ^ ref_f(r, sk);
                l = r;
                r = t;
            end else begin
                t = r ^ ref_f(l, sk);
                r = l;
                l = t;
            end
        end
        return {l, r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_valid(input int u);
        case (u)
            1:       return vld1;
            2:       return vld2;
            default: return vld16;
        endcase
    endfunction

    function automatic logic get_ready(input int u);
        case (u)
            1:       return rdy1;
            2:       return rdy2;
            default: return rdy16;
        endcase
    endfunction

    function automatic logic get_busy(input int u);
        case (u)
            1:       return bsy1;
            2:       return bsy2;
            default: return bsy16;
        endcase
    endfunction

    function automatic logic [63:0] get_ct(input int u);
        case (u)
            1:       return ct1;
            2:       return ct2;
            default: return ct16;
        endcase
    endfunction

    task automatic set_start(input int u, input logic v);
        st1  = (u == 1)  ? v : 1'b0;
        st2  = (u == 2)  ? v : 1'b0;
        st16 = (u == 16) ? v : 1'b0;
    endtask

    // Accept one block, scramble inputs afterwards, wait (bounded) for valid.
    // Returns at the sampling point inside the valid cycle.
    task automatic run_block(input int u, input logic [63:0] p, input logic [63:0] k,
                             input logic d, input int stray,
                             output logic [63:0] res, output int lat);
        @(negedge clk);
        check("ready_before_start", 64'(get_ready(u)), 64'd1);
        pt = p; key = k; dec = d;
        set_start(u, 1'b1);
        @(negedge clk);
        set_start(u, 1'b0);
        pt  = {$urandom(), $urandom()};
        key = {$urandom(), $urandom()};
        dec = 1'($urandom());
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (get_valid(u)) break;
            set_start(u, lat == stray);
        end
        set_start(u, 1'b0);
        res = get_ct(u);
        check("ready_in_valid_cycle", 64'(get_ready(u)), 64'd1);
        check("busy_in_valid_cycle", 64'(get_busy(u)), 64'd0);
    endtask

    typedef struct {
        int          sel;
        logic [63:0] p;
        logic [63:0] k;
        logic [63:0] exp;
    } vec_t;

    vec_t        tbl[5];
    logic [63:0] res, res2, first;
    int          lat, n, seen;
    logic        d;

    initial begin
        tbl[0] = '{1,  64'h0, 64'h617859626A636431, 64'h0000000061785962};
        tbl[1] = '{2,  64'h0, 64'h0, 64'h0000000000000001};
        tbl[2] = '{1,  64'h0000000100000000, 64'h0, 64'h0000000000000001};
        tbl[3] = '{2,  64'h0, 64'hFFFFFFFF00000000, 64'hFFFFFFFF000000FF};
        tbl[4] = '{16, 64'h426162656967796C, 64'h617859626A636431,
                   ref_model(64'h426162656967796C, 64'h617859626A636431, 16, 1'b0)};

        rst_n = 1'b0; pt = '0; key = '0; dec = 1'b0;
        st1 = 1'b0; st2 = 1'b0; st16 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(rdy16), 64'd1);
        check("reset_busy", 64'(bsy16), 64'd0);
        check("reset_valid", 64'(vld16), 64'd0);
        check("reset_ct", ct16, 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_block(tbl[v].sel, tbl[v].p, tbl[v].k, 1'b0, -1, res, lat);
            check($sformatf("vec%0d_ct", v), res, tbl[v].exp);
            check($sformatf("vec%0d_latency", v), 64'(lat), 64'(tbl[v].sel));
            @(negedge clk);
            check($sformatf("vec%0d_valid_one_cycle", v), 64'(get_valid(tbl[v].sel)), 64'd0);
            check($sformatf("vec%0d_ct_hold", v), get_ct(tbl[v].sel), tbl[v].exp);
        end

        // Stray start during RUN must be ignored.
        run_block(16, 64'h426162656967796C, 64'h617859626A636431, 1'b0, 5, res, lat);
        check("stray_start_ct", res, tbl[4].exp);
        check("stray_start_latency", 64'(lat), 64'd16);
        @(negedge clk);
        check("stray_start_not_queued", 64'(rdy16), 64'd1);

        // Back-to-back: new start in the valid cycle.
        run_block(16, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, -1, first, lat);
        check("b2b_first_ct", first, ref_model(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 16, 1'b0));
        pt = 64'h1122334455667788; key = 64'h99AABBCCDDEEFF00; dec = 1'b0;
        st16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0;
        check("b2b_accepted_busy", 64'(bsy16), 64'd1);
        pt = '0; key = '0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (vld16) break;
            check("b2b_first_ct_held", ct16, first);
        end
        check("b2b_second_latency", 64'(n), 64'd16);
        check("b2b_second_ct", ct16, ref_model(64'h1122334455667788, 64'h99AABBCCDDEEFF00, 16, 1'b0));

        // Randomized blocks against the reference model.
        for (int t = 0; t < 12; t++) begin
            logic [63:0] rp, rk;
            rp = {$urandom(), $urandom()};
            rk = {$urandom(), $urandom()};
`ifdef VOTE_CIPHER_DECRYPT_EN
            d = 1'($urandom());
`else
            d = 1'b0;
`endif
            run_block(16, rp, rk, d, -1, res, lat);
            check($sformatf("rand%0d_ct", t), res, ref_model(rp, rk, 16, d));
            check($sformatf("rand%0d_latency", t), 64'(lat), 64'd16);
        end

`ifdef VOTE_CIPHER_DECRYPT_EN
        run_block(16, 64'h426162656967796C, 64'h617859626A636431, 1'b0, -1, res, lat);
        run_block(16, res, 64'h617859626A636431, 1'b1, -1, res2, lat);
        check("decrypt_roundtrip", res2, 64'h426162656967796C);
        check("decrypt_latency", 64'(lat), 64'd16);
`endif

        // Reset mid-RUN aborts the block with no valid.
        @(negedge clk);
        pt = 64'hDEADBEEFCAFEF00D; key = 64'h0F1E2D3C4B5A6978; dec = 1'b0;
        st16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_reset_ready", 64'(rdy16), 64'd1);
        check("midrun_reset_busy", 64'(bsy16), 64'd0);
        check("midrun_reset_valid", 64'(vld16), 64'd0);
        check("midrun_reset_ct", ct16, 64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (vld16) seen++;
        end
        check("midrun_reset_no_valid", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
